// File: rtl/univ_shift_reg_if.sv
// Bus bundle for univ_shift_reg: control/data inputs and register/status outputs.
interface univ_shift_reg_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic             EN;
    logic [1:0]       MODE;
    logic             S_IN_R;
    logic             S_IN_L;
    logic [WIDTH-1:0] P_IN;
    logic             START;
    logic [WIDTH-1:0] Q;
    logic             S_OUT;
    logic             BUSY;
    logic             DONE;
    logic [CW-1:0]    CNT;

    // Driver side: supplies controls and data, observes the register.
    modport master (
        output EN, MODE, S_IN_R, S_IN_L, P_IN, START,
        input  Q, S_OUT, BUSY, DONE, CNT
    );

    // Register side.
    modport slave (
        input  EN, MODE, S_IN_R, S_IN_L, P_IN, START,
        output Q, S_OUT, BUSY, DONE, CNT
    );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold / shift right / shift left / parallel load,
// plus an automatic LSB-first WIDTH-bit serial transfer started by START.
// The interface instance must be built with the same WIDTH as this module.
module univ_shift_reg #(
    parameter int unsigned WIDTH  = 8,
    parameter bit          ROTATE = 1'b0
) (
    input  logic                 clk,
    input  logic                 R_,
    univ_shift_reg_if.slave      bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] q;
    logic [CW-1:0]    cnt;
    logic             busy;
    logic             done;
    logic             in_r;
    logic             in_l;

    // Bits entering each end: serial inputs, or the bit leaving the far end when rotating.
    assign in_r = ROTATE ? q[0]       : bus.S_IN_R;
    assign in_l = ROTATE ? q[WIDTH-1] : bus.S_IN_L;

    // Control FSM, data register, shift counter and status flags.
    // DONE clears on every edge regardless of EN so it is always one cycle wide.
    always_ff @(posedge clk or negedge R_) begin
        if (!R_) begin
            state <= IDLE;
            q     <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (bus.EN) begin
                unique case (state)
                    IDLE: begin
                        if (bus.START) begin
                            q     <= bus.P_IN;
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= XFER;
                        end else begin
                            unique case (bus.MODE)
                                2'b01:   q <= {in_r, q[WIDTH-1:1]};
                                2'b10:   q <= {q[WIDTH-2:0], in_l};
                                2'b11:   q <= bus.P_IN;
                                default: q <= q;
                            endcase
                        end
                    end
                    XFER: begin
                        q   <= {in_r, q[WIDTH-1:1]};
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(WIDTH - 1)) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.Q     = q;
    assign bus.S_OUT = q[0];
    assign bus.BUSY  = busy;
    assign bus.DONE  = done;
    assign bus.CNT   = cnt;
endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8), one plain and one rotating instance
// driven with identical stimulus.
module tb_univ_shift_reg;
    localparam int unsigned W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         r_n;
    logic         en;
    logic [1:0]   mode;
    logic         s_in_r;
    logic         s_in_l;
    logic [W-1:0] p_in;
    logic         start;

    int checks = 0;
    int errors = 0;

    univ_shift_reg_if #(.WIDTH(W)) bus0 ();
    univ_shift_reg_if #(.WIDTH(W)) bus1 ();

    assign bus0.EN = en;      assign bus1.EN = en;
    assign bus0.MODE = mode;  assign bus1.MODE = mode;
    assign bus0.S_IN_R = s_in_r; assign bus1.S_IN_R = s_in_r;
    assign bus0.S_IN_L = s_in_l; assign bus1.S_IN_L = s_in_l;
    assign bus0.P_IN = p_in;  assign bus1.P_IN = p_in;
    assign bus0.START = start; assign bus1.START = start;

    univ_shift_reg #(.WIDTH(W), .ROTATE(1'b0)) dut0 (.clk(clk), .R_(r_n), .bus(bus0.slave));
    univ_shift_reg #(.WIDTH(W), .ROTATE(1'b1)) dut1 (.clk(clk), .R_(r_n), .bus(bus1.slave));

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic       sr;
        logic       sl;
        logic [7:0] p;
        logic [7:0] exp_q;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        en = 1'b1; mode = 2'b00; start = 1'b0;
        s_in_r = 1'b0; s_in_l = 1'b0; p_in = '0;
    endtask

    // Automatic transfer of p, optionally stalled (EN=0) and disturbed by START/MODE/P_IN.
    task automatic run_xfer(input logic [7:0] p, input int stall_at, input int stall_len,
                            input bit interfere, input string tag);
        int edges;
        p_in = p; start = 1'b1; en = 1'b1; mode = 2'b00; s_in_r = 1'b0;
        step();
        start = 1'b0;
        edges = 0;
        chk({tag, " load_q"}, 64'(bus0.Q), 64'(p));
        for (int i = 0; i < 8; i++) begin
            if (i == stall_at) begin
                en = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    if (interfere) begin start = 1'b1; mode = 2'b11; p_in = ~p; end
                    step();
                    edges++;
                    chk({tag, " stall_sout"}, 64'(bus0.S_OUT), 64'(p[i]));
                    chk({tag, " stall_busy"}, 64'(bus0.BUSY), 64'(1));
                    chk({tag, " stall_cnt"}, 64'(bus0.CNT), 64'(i));
                    chk({tag, " stall_done"}, 64'(bus0.DONE), 64'(0));
                end
                en = 1'b1; start = 1'b0; mode = 2'b00; p_in = p;
            end
            chk({tag, " sout"}, 64'(bus0.S_OUT), 64'(p[i]));
            chk({tag, " sout_rot"}, 64'(bus1.S_OUT), 64'(p[i]));
            chk({tag, " busy"}, 64'(bus0.BUSY), 64'(1));
            chk({tag, " done_early"}, 64'(bus0.DONE), 64'(0));
            chk({tag, " cnt"}, 64'(bus0.CNT), 64'(i));
            if (interfere && i == 2) begin start = 1'b1; mode = 2'b11; p_in = ~p; end
            step();
            edges++;
            start = 1'b0; mode = 2'b00; p_in = p;
        end
        chk({tag, " done_latency"}, 64'(edges), 64'(8 + stall_len));
        chk({tag, " done"}, 64'(bus0.DONE), 64'(1));
        chk({tag, " busy_end"}, 64'(bus0.BUSY), 64'(0));
        chk({tag, " cnt_end"}, 64'(bus0.CNT), 64'(8));
        chk({tag, " q_end"}, 64'(bus0.Q), 64'(0));
        chk({tag, " q_end_rot"}, 64'(bus1.Q), 64'(p));
    endtask

    // Reference model state for the random phase.
    logic [7:0] mq0, mq1;
    int         mleft, mcnt;
    logic       mdone;

    task automatic model_edge();
        logic nd;
        nd = 1'b0;
        if (en) begin
            if (mleft == 0) begin
                if (start) begin
                    mq0 = p_in; mq1 = p_in; mcnt = 0; mleft = 8;
                end else if (mode == 2'b01) begin
                    mq0 = (mq0 >> 1) | (8'(s_in_r) << 7);
                    mq1 = (mq1 >> 1) | (8'(mq1[0]) << 7);
                end else if (mode == 2'b10) begin
                    mq0 = (mq0 << 1) | 8'(s_in_l);
                    mq1 = (mq1 << 1) | 8'(mq1[7]);
                end else if (mode == 2'b11) begin
                    mq0 = p_in; mq1 = p_in;
                end
            end else begin
                mq0 = (mq0 >> 1) | (8'(s_in_r) << 7);
                mq1 = (mq1 >> 1) | (8'(mq1[0]) << 7);
                mcnt++;
                mleft--;
                if (mleft == 0) nd = 1'b1;
            end
        end
        mdone = nd;
    endtask

    initial begin
        tbl[0] = '{1'b1, 2'b11, 1'b0, 1'b0, 8'hA5, 8'hA5};
        tbl[1] = '{1'b1, 2'b01, 1'b1, 1'b0, 8'h00, 8'hD2};
        tbl[2] = '{1'b1, 2'b10, 1'b0, 1'b0, 8'h00, 8'hA4};
        tbl[3] = '{1'b1, 2'b00, 1'b1, 1'b1, 8'hFF, 8'hA4};
        tbl[4] = '{1'b0, 2'b11, 1'b0, 1'b0, 8'h00, 8'hA4};
        tbl[5] = '{1'b1, 2'b10, 1'b0, 1'b1, 8'h00, 8'h49};
        tbl[6] = '{1'b1, 2'b01, 1'b0, 1'b0, 8'h00, 8'h24};
        tbl[7] = '{1'b1, 2'b11, 1'b0, 1'b0, 8'h3C, 8'h3C};

        r_n = 1'b0;
        quiet_inputs();
        #12;
        chk("rst_q", 64'(bus0.Q), 64'(0));
        chk("rst_busy", 64'(bus0.BUSY), 64'(0));
        chk("rst_done", 64'(bus0.DONE), 64'(0));
        chk("rst_cnt", 64'(bus0.CNT), 64'(0));
        r_n = 1'b1;
        step();

        // Asynchronous reset mid-cycle clears a loaded value before the next edge.
        mode = 2'b11; p_in = 8'h5A;
        step();
        chk("pre_rst_q", 64'(bus0.Q), 64'(8'h5A));
        #3 r_n = 1'b0;
        #1;
        chk("async_rst_q", 64'(bus0.Q), 64'(0));
        chk("async_rst_busy", 64'(bus0.BUSY), 64'(0));
        chk("async_rst_cnt", 64'(bus0.CNT), 64'(0));
        #2 r_n = 1'b1;
        quiet_inputs();
        step();

        // Manual modes from the vector table.
        for (int i = 0; i < 8; i++) begin
            en = tbl[i].en; mode = tbl[i].mode; s_in_r = tbl[i].sr;
            s_in_l = tbl[i].sl; p_in = tbl[i].p;
            step();
            chk($sformatf("tbl%0d_q", i), 64'(bus0.Q), 64'(tbl[i].exp_q));
            chk($sformatf("tbl%0d_sout", i), 64'(bus0.S_OUT), 64'(tbl[i].exp_q[0]));
            chk($sformatf("tbl%0d_busy", i), 64'(bus0.BUSY), 64'(0));
        end
        quiet_inputs();

        // Plain transfer, then DONE must drop even with EN low.
        run_xfer(8'h96, -1, 0, 1'b0, "x96");
        en = 1'b0;
        step();
        chk("done_width_en0", 64'(bus0.DONE), 64'(0));
        chk("cnt_hold", 64'(bus0.CNT), 64'(8));
        en = 1'b1;
        step();
        chk("cnt_hold2", 64'(bus0.CNT), 64'(8));

        // Interference and 3-cycle stall; the following START lands in the DONE cycle.
        run_xfer(8'h96, 4, 3, 1'b1, "intf");
        run_xfer(8'h5A, -1, 0, 1'b0, "b2b");
        step();
        chk("b2b_done_clear", 64'(bus0.DONE), 64'(0));

        // Abort after the fourth shift.
        p_in = 8'h96; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("abort_cnt4", 64'(bus0.CNT), 64'(4));
        #3 r_n = 1'b0;
        #1;
        chk("abort_q", 64'(bus0.Q), 64'(0));
        chk("abort_busy", 64'(bus0.BUSY), 64'(0));
        chk("abort_cnt", 64'(bus0.CNT), 64'(0));
        #2 r_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("abort_no_done", 64'(bus0.DONE), 64'(0));
            chk("abort_idle", 64'(bus0.BUSY), 64'(0));
        end
        run_xfer(8'hFF, -1, 0, 1'b0, "xff");
        step();

        // Rotate instance, manual modes.
        mode = 2'b11; p_in = 8'h81;
        step();
        chk("rot_load", 64'(bus1.Q), 64'(8'h81));
        mode = 2'b01;
        step();
        chk("rot_right", 64'(bus1.Q), 64'(8'hC0));
        mode = 2'b10;
        step();
        chk("rot_left", 64'(bus1.Q), 64'(8'h81));
        mode = 2'b00;
        run_xfer(8'h3C, -1, 0, 1'b0, "rot3c");
        step();

        // Random stimulus against the reference model.
        r_n = 1'b0;
        #2;
        r_n = 1'b1;
        mq0 = '0; mq1 = '0; mleft = 0; mcnt = 0; mdone = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            en = ($urandom % 8) != 0;
            mode = 2'($urandom % 4);
            s_in_r = 1'($urandom % 2);
            s_in_l = 1'($urandom % 2);
            p_in = 8'($urandom);
            start = ($urandom % 6) == 0;
            model_edge();
            step();
            chk("rnd_q", 64'(bus0.Q), 64'(mq0));
            chk("rnd_q_rot", 64'(bus1.Q), 64'(mq1));
            chk("rnd_sout", 64'(bus0.S_OUT), 64'(mq0[0]));
            chk("rnd_busy", 64'(bus0.BUSY), 64'(mleft != 0));
            chk("rnd_done", 64'(bus0.DONE), 64'(mdone));
            chk("rnd_cnt", 64'(bus0.CNT), 64'(mcnt));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning register width in bits (legal range 2..64).
REQ-002 The block SHALL have parameter ROTATE, default 0, meaning that when 1 the bit leaving the register re-enters at the opposite end instead of the serial input.
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port R_  input  1  reset, asynchronous, active-low.
REQ-005 Port EN  input  1  clock enable; low freezes Q, CNT and the FSM.
REQ-006 Port MODE  input  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-007 Port S_IN_R  input  1  serial bit entering Q[WIDTH-1] on a right shift.
REQ-008 Port S_IN_L  input  1  serial bit entering Q[0] on a left shift.
REQ-009 Port P_IN  input  WIDTH  parallel load data.
REQ-010 Port START  input  1  request for an automatic WIDTH-bit serial transfer, LSB first.
REQ-011 Port Q  output  WIDTH  register contents.
REQ-012 Port S_OUT  output  1  serial output, equal to Q[0] combinationally.
REQ-013 Port BUSY  output  1  high while an automatic transfer is in progress.
REQ-014 Port DONE  output  1  one-cycle pulse marking transfer completion.
REQ-015 Port CNT  output  clog2(WIDTH+1)  number of shifts completed in the current transfer.

Function
REQ-016 The FSM SHALL have exactly two states, IDLE and XFER.
REQ-017 In IDLE with EN=1 and START=0, MODE SHALL act on Q as follows: 00 holds; 01 gives Q <= {S_IN_R, Q[WIDTH-1:1]}; 10 gives Q <= {Q[WIDTH-2:0], S_IN_L}; 11 gives Q <= P_IN.
REQ-018 With ROTATE=1, S_IN_R SHALL be replaced by Q[0] and S_IN_L SHALL be replaced by Q[WIDTH-1], in both manual and automatic shifts.
REQ-019 In IDLE with EN=1, START=1 SHALL take priority over MODE: Q <= P_IN, CNT <= 0, BUSY <= 1, and the state moves to XFER.
REQ-020 In XFER, each edge with EN=1 SHALL perform one right shift (per REQ-017/018) and increment CNT.
REQ-021 The edge on which CNT goes from WIDTH-1 to WIDTH SHALL return the FSM to IDLE, clear BUSY, and set DONE for exactly the following clock cycle.
REQ-022 On that same edge CNT SHALL hold WIDTH, and it SHALL stay at WIDTH until the next START or reset.
REQ-023 S_OUT SHALL present P_IN[i] during the i-th enabled cycle after the load, for i = 0..WIDTH-1.
REQ-024 In XFER, MODE and START SHALL be ignored; a START during BUSY SHALL be dropped, not queued.
REQ-025 A START in the same cycle that DONE is high SHALL be accepted as a new transfer.
REQ-026 EN=0 SHALL stall the transfer without losing bits; BUSY SHALL stay high through the stall.
REQ-027 DONE SHALL be a single clk cycle wide regardless of EN, and SHALL never assert outside a completed transfer.

Reset
REQ-028 R_=0 SHALL immediately, independent of clk, force Q=0, CNT=0, BUSY=0, DONE=0 and state IDLE.
REQ-029 A reset during XFER SHALL abort the transfer with no DONE pulse.
REQ-030 The first enabled edge after R_ deasserts SHALL behave per REQ-017/019.

Verification
REQ-031 Reset: drive R_ low asynchronously mid-cycle -> Q=00, BUSY=0, DONE=0 and CNT=0 before the next clk edge.
REQ-032 Manual modes (WIDTH=8): MODE=11 with P_IN=A5 -> Q=A5; then MODE=01 with S_IN_R=1 -> Q=D2; then MODE=10 with S_IN_L=0 -> Q=A4; then MODE=00 -> Q stays A4.
REQ-033 Transfer: START with P_IN=96 and S_IN_R=0 -> S_OUT sequence 0,1,1,0,1,0,0,1; BUSY high for 8 cycles; DONE high in cycle 9 only; final Q=00 and CNT=8.
REQ-034 Interference: during a transfer, pulse START, set MODE=11 and hold EN=0 for 3 cycles -> no reload occurs, the bit sequence is unchanged and DONE is delayed by exactly 3 cycles.
REQ-035 Abort: assert R_ after the 4th shift -> Q=00 and BUSY=0 with no DONE; a subsequent START with P_IN=FF completes normally.
REQ-036 Rotate (ROTATE=1): load 81, then MODE=01 -> Q=C0; an 8-shift automatic transfer of 3C -> final Q=3C.
